// File: rtl/vector_exec_sequencer.sv
// Expands one vector ALU instruction held in Decode into per-element scalar operations,
// then drains the execute pipeline before releasing Fetch/Decode.
module vector_exec_sequencer #(
   parameter int unsigned REG_W        = 4,
   parameter int unsigned LEN_W        = 4,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             startD,
   input  logic [LEN_W-1:0] vlenD,
   input  logic [REG_W-1:0] rs1BaseD,
   input  logic [REG_W-1:0] rs2BaseD,
   input  logic [REG_W-1:0] rdBaseD,
   input  logic [3:0]       aluControlD,
   input  logic             scalarSrc2D,
   input  logic             flushE,
   output logic             stallF,
   output logic             stallD,
   output logic             busy,
   output logic [REG_W-1:0] ra1,
   output logic [REG_W-1:0] ra2,
   output logic [REG_W-1:0] rdV,
   output logic [3:0]       aluControlV,
   output logic             regWriteV,
   output logic [LEN_W-1:0] elemIdx,
   output logic             done
);

   // DRAIN_CYCLES is expected to be at least 1.
   localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] vlen_q, vlen_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [REG_W-1:0] rs1_q, rs1_d;
   logic [REG_W-1:0] rs2_q, rs2_d;
   logic [REG_W-1:0] rd_q, rd_d;
   logic [3:0]       alu_q, alu_d;
   logic             scalar_q, scalar_d;

   logic             start_ok;
   logic [REG_W-1:0] idx_r;

   assign start_ok = startD && (vlenD != '0) && !flushE;
   assign idx_r    = REG_W'(idx_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         vlen_q   <= '0;
         cnt_q    <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         alu_q    <= '0;
         scalar_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         vlen_q   <= vlen_d;
         cnt_q    <= cnt_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rd_q     <= rd_d;
         alu_q    <= alu_d;
         scalar_q <= scalar_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      vlen_d   = vlen_q;
      cnt_d    = cnt_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      rd_d     = rd_q;
      alu_d    = alu_q;
      scalar_d = scalar_q;
      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               rs1_d    = rs1BaseD;
               rs2_d    = rs2BaseD;
               rd_d     = rdBaseD;
               vlen_d   = vlenD;
               alu_d    = aluControlD;
               scalar_d = scalarSrc2D;
               idx_d    = '0;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            if (flushE) begin
               state_d = StIdle;
            end else if (idx_q == vlen_q - LEN_W'(1)) begin
               cnt_d   = CntW'(DRAIN_CYCLES);
               state_d = StDrain;
            end else begin
               idx_d = idx_q + LEN_W'(1);
            end
         end
         StDrain: begin
            if (flushE) begin
               state_d = StIdle;
            end else if (cnt_q == CntW'(1)) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StDone: begin
            // The vector instruction itself advances now; startD is not re-sampled.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      stallF      = 1'b0;
      busy        = 1'b0;
      ra1         = '0;
      ra2         = '0;
      rdV         = '0;
      aluControlV = '0;
      regWriteV   = 1'b0;
      done        = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Gated by rst so every output reads 0 while reset is held.
            stallF = start_ok && !rst;
         end
         StIssue: begin
            stallF      = 1'b1;
            busy        = 1'b1;
            regWriteV   = 1'b1;
            ra1         = rs1_q + idx_r;
            ra2         = scalar_q ? rs2_q : rs2_q + idx_r;
            rdV         = rd_q + idx_r;
            aluControlV = alu_q;
         end
         StDrain: begin
            stallF = 1'b1;
            busy   = 1'b1;
         end
         StDone: begin
            done = 1'b1;
         end
         default: begin
            stallF = 1'b0;
         end
      endcase
   end

   assign stallD  = stallF;
   assign elemIdx = idx_q;

endmodule
